// File: rtl/mem_access_pkg.sv
// Shared memory-stage definitions: bus width macro, MEMOP codes, FSM encodings, lane helpers.
// Latency: n/a (declarations and pure combinational helper functions).
// Backpressure: n/a.
`ifndef WORD_BUS
`define WORD_BUS 32
`endif

package mem_access_pkg;

    localparam logic [3:0] MEMOP_NONE = 4'd0;
    localparam logic [3:0] MEMOP_LB   = 4'd1;
    localparam logic [3:0] MEMOP_LH   = 4'd2;
    localparam logic [3:0] MEMOP_LW   = 4'd3;
    localparam logic [3:0] MEMOP_LBU  = 4'd4;
    localparam logic [3:0] MEMOP_LHU  = 4'd5;
    localparam logic [3:0] MEMOP_SB   = 4'd6;
    localparam logic [3:0] MEMOP_SH   = 4'd7;
    localparam logic [3:0] MEMOP_SW   = 4'd8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Codes above SW are not instructions; they behave like a plain ALU pass-through.
    function automatic logic [3:0] memop_norm(input logic [3:0] op);
        return (op > MEMOP_SW) ? MEMOP_NONE : op;
    endfunction

    // Access size: 0 none, 1 byte, 2 half, 3 word.
    function automatic logic [1:0] memop_size(input logic [3:0] op);
        case (op)
            MEMOP_LB, MEMOP_LBU, MEMOP_SB: return 2'd1;
            MEMOP_LH, MEMOP_LHU, MEMOP_SH: return 2'd2;
            MEMOP_LW, MEMOP_SW:            return 2'd3;
            default:                       return 2'd0;
        endcase
    endfunction

    function automatic logic memop_is_store(input logic [3:0] op);
        return (op == MEMOP_SB) || (op == MEMOP_SH) || (op == MEMOP_SW);
    endfunction

    // Byte enables: bytes follow addr[1:0], halves follow addr[1], words cover all lanes.
    function automatic logic [3:0] memop_be(input logic [3:0] op, input logic [1:0] lo);
        case (memop_size(op))
            2'd1:    return 4'b0001 << lo;
            2'd2:    return lo[1] ? 4'b1100 : 4'b0011;
            2'd3:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Replicate the store value across lanes so the byte enables alone pick the target.
    function automatic logic [`WORD_BUS-1:0] memop_wdata(input logic [3:0] op,
                                                        input logic [`WORD_BUS-1:0] data);
        case (memop_size(op))
            2'd1:    return {4{data[7:0]}};
            2'd2:    return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic memop_misaligned(input logic [3:0] op, input logic [1:0] lo);
        return ((memop_size(op) == 2'd2) && lo[0]) || ((memop_size(op) == 2'd3) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory req/ack bus between the memory stage (master) and the data memory (slave).
// Latency: n/a (wires only).
// Backpressure: master holds the request fields stable until mem_ack is sampled high.
interface mem_access_if #(parameter int WORD_W = `WORD_BUS);
    logic              mem_req;
    logic              mem_we;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_ack;
    logic [WORD_W-1:0] mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
                    input  mem_ack, mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
                    output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_load_align.sv
// Load alignment: picks the addressed byte/half from the read word and sign/zero extends it.
// Latency: combinational.
// Backpressure: none.
module mem_load_align
    import mem_access_pkg::*;
#(
    parameter int WORD_W = `WORD_BUS
) (
    input  logic [3:0]        op,
    input  logic [1:0]        addr_lo,
    input  logic [WORD_W-1:0] rdata,
    output logic [WORD_W-1:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane select followed by width extension for the latched load op.
    always_comb begin
        case (addr_lo)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            MEMOP_LB:  data = {{(WORD_W-8){byte_v[7]}}, byte_v};
            MEMOP_LBU: data = {{(WORD_W-8){1'b0}}, byte_v};
            MEMOP_LH:  data = {{(WORD_W-16){half_v[15]}}, half_v};
            MEMOP_LHU: data = {{(WORD_W-16){1'b0}}, half_v};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory stage: one req/ack data-memory transaction per load/store, registered writeback result.
// Latency: 1 cycle for non-memory ops, 1 + ack wait cycles for loads/stores.
// Backpressure: o_stall is high while a transaction is outstanding; inputs are ignored then.
// Optional misaligned-access trap selected by defining MEM_MISALIGN_CHECK_EN.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int WORD_W = `WORD_BUS,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [WORD_W-1:0] i_exResult,
    input  logic [3:0]        i_memOp,
    input  logic [WORD_W-1:0] i_storeData,
    input  logic [REG_AW-1:0] i_destReg,
    input  logic              i_regWe,
    output logic              o_stall,
    mem_access_if.master      mem,
    output logic              o_valid,
    output logic [WORD_W-1:0] o_wbData,
    output logic [REG_AW-1:0] o_wbReg,
    output logic              o_wbWe,
    output logic              o_excMisalign
);

    logic [0:0]        state_q,     state_d;
    logic              mem_we_q,    mem_we_d;
    logic [WORD_W-1:0] mem_addr_q,  mem_addr_d;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q,    mem_be_d;
    logic [3:0]        op_q,        op_d;
    logic [1:0]        addr_lo_q,   addr_lo_d;
    logic [REG_AW-1:0] dest_q,      dest_d;
    logic              regwe_q,     regwe_d;
    logic              valid_q,     valid_d;
    logic [WORD_W-1:0] wb_data_q,   wb_data_d;
    logic [REG_AW-1:0] wb_reg_q,    wb_reg_d;
    logic              wb_we_q,     wb_we_d;
`ifdef MEM_MISALIGN_CHECK_EN
    logic              exc_q,       exc_d;
`endif

    logic [3:0]        in_op;
    logic [WORD_W-1:0] load_word;

    assign in_op = memop_norm(i_memOp);

    mem_load_align #(.WORD_W(WORD_W)) u_load_align (
        .op      (op_q),
        .addr_lo (addr_lo_q),
        .rdata   (mem.mem_rdata),
        .data    (load_word)
    );

    // Next-state: accept an instruction in IDLE, wait for ack in BUSY, pulse the result.
    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        op_d        = op_q;
        addr_lo_d   = addr_lo_q;
        dest_d      = dest_q;
        regwe_d     = regwe_q;
        valid_d     = 1'b0;
        wb_data_d   = wb_data_q;
        wb_reg_d    = wb_reg_q;
        wb_we_d     = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
        exc_d       = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    if (in_op == MEMOP_NONE) begin
                        valid_d   = 1'b1;
                        wb_data_d = i_exResult;
                        wb_reg_d  = i_destReg;
                        wb_we_d   = i_regWe;
                    end
`ifdef MEM_MISALIGN_CHECK_EN
                    else if (memop_misaligned(in_op, i_exResult[1:0])) begin
                        // Trap without touching the bus; the faulting address is reported.
                        valid_d   = 1'b1;
                        wb_data_d = i_exResult;
                        wb_reg_d  = i_destReg;
                        exc_d     = 1'b1;
                    end
`endif
                    else begin
                        state_d     = ST_BUSY;
                        mem_we_d    = memop_is_store(in_op);
                        mem_addr_d  = {i_exResult[WORD_W-1:2], 2'b00};
                        mem_wdata_d = memop_wdata(in_op, i_storeData);
                        mem_be_d    = memop_be(in_op, i_exResult[1:0]);
                        op_d        = in_op;
                        addr_lo_d   = i_exResult[1:0];
                        dest_d      = i_destReg;
                        regwe_d     = i_regWe;
                    end
                end
            end
            default: begin
                if (mem.mem_ack) begin
                    state_d   = ST_IDLE;
                    valid_d   = 1'b1;
                    wb_data_d = mem_we_q ? '0 : load_word;
                    wb_reg_d  = dest_q;
                    wb_we_d   = regwe_q & ~mem_we_q;
                end
            end
        endcase
    end

    // State and output registers; reset abandons any outstanding request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            op_q        <= MEMOP_NONE;
            addr_lo_q   <= '0;
            dest_q      <= '0;
            regwe_q     <= 1'b0;
            valid_q     <= 1'b0;
            wb_data_q   <= '0;
            wb_reg_q    <= '0;
            wb_we_q     <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
            exc_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            op_q        <= op_d;
            addr_lo_q   <= addr_lo_d;
            dest_q      <= dest_d;
            regwe_q     <= regwe_d;
            valid_q     <= valid_d;
            wb_data_q   <= wb_data_d;
            wb_reg_q    <= wb_reg_d;
            wb_we_q     <= wb_we_d;
`ifdef MEM_MISALIGN_CHECK_EN
            exc_q       <= exc_d;
`endif
        end
    end

    assign o_stall       = (state_q == ST_BUSY);
    assign mem.mem_req   = (state_q == ST_BUSY);
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_be    = mem_be_q;
    assign o_valid       = valid_q;
    assign o_wbData      = wb_data_q;
    assign o_wbReg       = wb_reg_q;
    assign o_wbWe        = wb_we_q;
`ifdef MEM_MISALIGN_CHECK_EN
    assign o_excMisalign = exc_q;
`else
    assign o_excMisalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed scenarios then random ops against an arithmetic reference model.
// Latency: n/a.
// Backpressure: acks are delayed a random number of cycles while junk is driven upstream.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic [31:0] i_exResult;
    logic [3:0]  i_memOp;
    logic [31:0] i_storeData;
    logic [4:0]  i_destReg;
    logic        i_regWe;
    logic        o_stall;
    logic        o_valid;
    logic [31:0] o_wbData;
    logic [4:0]  o_wbReg;
    logic        o_wbWe;
    logic        o_excMisalign;

    int n_cmp = 0;
    int n_fail = 0;
    int stall_seen = 0;

    always #5 clk = ~clk;

    mem_access_if #(.WORD_W(32)) bus ();

    mem_access #(.WORD_W(32), .REG_AW(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_valid       (i_valid),
        .i_exResult    (i_exResult),
        .i_memOp       (i_memOp),
        .i_storeData   (i_storeData),
        .i_destReg     (i_destReg),
        .i_regWe       (i_regWe),
        .o_stall       (o_stall),
        .mem           (bus),
        .o_valid       (o_valid),
        .o_wbData      (o_wbData),
        .o_wbReg       (o_wbReg),
        .o_wbWe        (o_wbWe),
        .o_excMisalign (o_excMisalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes (0 = not a memory op).
    function automatic int op_size(input logic [3:0] op);
        case (op)
            4'd1, 4'd4, 4'd6: return 1;
            4'd2, 4'd5, 4'd7: return 2;
            4'd3, 4'd8:       return 4;
            default:          return 0;
        endcase
    endfunction

    function automatic bit is_misal(input logic [3:0] op, input logic [31:0] addr);
`ifdef MEM_MISALIGN_CHECK_EN
        return (op_size(op) == 2 && addr[0]) || (op_size(op) == 4 && addr[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (o_stall) stall_seen++;
    endtask

    task automatic idle_chk();
        tick();
        chk("idle_valid", 32'(o_valid), 32'd0);
        chk("idle_wbwe", 32'(o_wbWe), 32'd0);
        chk("idle_exc", 32'(o_excMisalign), 32'd0);
    endtask

    // Present one instruction, service the bus after wait_n empty request cycles, check the result.
    task automatic do_op(input logic [3:0] op, input logic [31:0] ex, input logic [31:0] sdata,
                         input logic [31:0] rdata, input int wait_n, input logic [4:0] dreg,
                         input logic we);
        int s;
        int off;
        bit st;
        bit sg;
        bit ma;
        logic [31:0] mask;
        logic [31:0] be;
        logic [31:0] wd;
        logic [31:0] ld;
        s    = op_size(op);
        st   = (op >= 4'd6 && op <= 4'd8);
        sg   = (op == 4'd1 || op == 4'd2);
        ma   = is_misal(op, ex);
        off  = (s == 1) ? int'(ex[1:0]) : (s == 2) ? (int'(ex[1:0]) / 2) * 2 : 0;
        mask = (s == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * s)) - 32'd1;
        be   = ((32'd1 << s) - 32'd1) << off;
        wd   = (sdata & mask) * ((s == 1) ? 32'h0101_0101 : (s == 2) ? 32'h0001_0001 : 32'd1);
        ld   = (rdata >> (8 * off)) & mask;
        if (sg && ld[8 * s - 1]) ld = ld | ~mask;

        chk("accept_stall", 32'(o_stall), 32'd0);
        i_valid = 1'b1; i_memOp = op; i_exResult = ex; i_storeData = sdata;
        i_destReg = dreg; i_regWe = we;
        tick();
        if (s == 0) begin
            i_valid = 1'b0;
            chk("nm_valid", 32'(o_valid), 32'd1);
            chk("nm_data", o_wbData, ex);
            chk("nm_reg", 32'(o_wbReg), 32'(dreg));
            chk("nm_we", 32'(o_wbWe), 32'(we));
            chk("nm_req", 32'(bus.mem_req), 32'd0);
        end else if (ma) begin
            i_valid = 1'b0;
            chk("ma_valid", 32'(o_valid), 32'd1);
            chk("ma_we", 32'(o_wbWe), 32'd0);
            chk("ma_req", 32'(bus.mem_req), 32'd0);
            chk("ma_stall", 32'(o_stall), 32'd0);
        end else begin
            for (int i = 0; i <= wait_n; i++) begin
                i_valid = 1'b1; i_memOp = 4'($urandom); i_exResult = $urandom;
                i_storeData = $urandom; i_destReg = 5'($urandom); i_regWe = 1'b1;
                chk("busy_req", 32'(bus.mem_req), 32'd1);
                chk("busy_stall", 32'(o_stall), 32'd1);
                chk("busy_we", 32'(bus.mem_we), 32'(st));
                chk("busy_addr", bus.mem_addr, {ex[31:2], 2'b00});
                chk("busy_be", 32'(bus.mem_be), be);
                if (st) chk("busy_wdata", bus.mem_wdata, wd);
                chk("busy_valid", 32'(o_valid), 32'd0);
                bus.mem_ack   = (i == wait_n);
                bus.mem_rdata = (i == wait_n) ? rdata : $urandom;
                tick();
            end
            bus.mem_ack = 1'b0;
            i_valid = 1'b0;
            chk("done_valid", 32'(o_valid), 32'd1);
            if (!st) chk("done_data", o_wbData, ld);
            chk("done_we", 32'(o_wbWe), st ? 32'd0 : 32'(we));
            chk("done_reg", 32'(o_wbReg), 32'(dreg));
            chk("done_req", 32'(bus.mem_req), 32'd0);
            chk("done_stall", 32'(o_stall), 32'd0);
        end
        chk("exc", 32'(o_excMisalign), 32'(ma));
    endtask

    initial begin
        int st0;
        rst_n = 1'b0; i_valid = 1'b0; i_exResult = '0; i_memOp = '0; i_storeData = '0;
        i_destReg = '0; i_regWe = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        #12;
        chk("rst_req", 32'(bus.mem_req), 32'd0);
        chk("rst_stall", 32'(o_stall), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_wbdata", o_wbData, 32'd0);
        chk("rst_wbreg", 32'(o_wbReg), 32'd0);
        chk("rst_wbwe", 32'(o_wbWe), 32'd0);
        chk("rst_be", 32'(bus.mem_be), 32'd0);
        chk("rst_addr", bus.mem_addr, 32'd0);
        chk("rst_exc", 32'(o_excMisalign), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Non-memory pass-through never stalls.
        st0 = stall_seen;
        do_op(4'd0, 32'h1234_5678, 32'h0, 32'h0, 0, 5'd3, 1'b1);
        chk("nm_no_stall", 32'(stall_seen - st0), 32'd0);
        idle_chk();

        // Signed byte load from lane 3 with two empty request cycles.
        st0 = stall_seen;
        do_op(4'd1, 32'h0000_0103, 32'h0, 32'h8012_3456, 2, 5'd7, 1'b1);
        chk("lb_stall_cycles", 32'(stall_seen - st0), 32'd3);
        chk("lb_value", o_wbData, 32'hFFFF_FF80);
        idle_chk();

        // Upper-half store.
        do_op(4'd7, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 1, 5'd9, 1'b1);
        idle_chk();

        // Immediate-ack word loads issued back to back.
        do_op(4'd3, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 0, 5'd1, 1'b1);
        do_op(4'd3, 32'h0000_0304, 32'h0, 32'h1357_9BDF, 0, 5'd2, 1'b1);
        idle_chk();

        // Reset while a request is outstanding; a later ack must be ignored.
        i_valid = 1'b1; i_memOp = 4'd3; i_exResult = 32'h0000_0400; i_destReg = 5'd4; i_regWe = 1'b1;
        tick();
        i_valid = 1'b0;
        chk("abort_req_before", 32'(bus.mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_req", 32'(bus.mem_req), 32'd0);
        chk("abort_stall", 32'(o_stall), 32'd0);
        chk("abort_valid", 32'(o_valid), 32'd0);
        tick();
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stray_ack_valid", 32'(o_valid), 32'd0);
            chk("stray_ack_req", 32'(bus.mem_req), 32'd0);
        end
        bus.mem_ack = 1'b0;

        // Misaligned word access.
        do_op(4'd3, 32'h0000_0101, 32'h0, 32'h0BAD_C0DE, 0, 5'd5, 1'b1);
        idle_chk();

        // Random traffic, including undefined op codes and random ack delays.
        for (int n = 0; n < 200; n++) begin
            do_op(4'($urandom), $urandom, $urandom, $urandom, int'($urandom_range(3, 0)),
                  5'($urandom), 1'($urandom));
            if ($urandom_range(1, 0) == 1) idle_chk();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
